// File: rtl/io_bus_bridge_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_bus_bridge_pkg : size codes, peripheral map and read-select encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package io_bus_bridge_pkg;

  localparam logic [1:0]  SIZE_B        = 2'b00;
  localparam logic [1:0]  SIZE_H        = 2'b01;
  localparam logic [1:0]  SIZE_W        = 2'b10;

  localparam logic [31:0] PERI_BASE_DEF = 32'hFFFF_F000;

  localparam logic [31:0] OFF_TUBE      = 32'h0000_0000;
  localparam logic [31:0] OFF_CNT       = 32'h0000_0020;
  localparam logic [31:0] OFF_CMP       = 32'h0000_0024;
  localparam logic [31:0] OFF_STAT      = 32'h0000_0028;
  localparam logic [31:0] OFF_LED       = 32'h0000_0060;
  localparam logic [31:0] OFF_SW        = 32'h0000_0070;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_DRAM = 3'd1,
    SEL_TUBE = 3'd2,
    SEL_LED  = 3'd3,
    SEL_SW   = 3'd4,
    SEL_CNT  = 3'd5,
    SEL_CMP  = 3'd6,
    SEL_STAT = 3'd7
  } rd_sel_e;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    lane_merge = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) lane_merge[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_lane_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_lane_gen : byte enables, lane-replicated data and misalign detect
// Rev 1.0
// ----------------------------------------------------------------------------
module io_lane_gen
  import io_bus_bridge_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [3:0]  be;
  logic [31:0] data;
  logic        mis;

  // Reserved size code falls through to the word case.
  always_comb begin
    be   = 4'b1111;
    data = wd_i;
    mis  = |addr_lo_i;
    case (size_i)
      SIZE_B: begin
        be   = 4'b0001 << addr_lo_i;
        data = {4{wd_i[7:0]}};
        mis  = 1'b0;
      end
      SIZE_H: begin
        be   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        data = {2{wd_i[15:0]}};
        mis  = addr_lo_i[0];
      end
      default: ;
    endcase
    if (mis) be = 4'b0000;
  end

  assign be_o       = be;
  assign data_o     = data;
  assign misalign_o = mis;

endmodule
`default_nettype wire

// File: rtl/io_bus_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_bus_bridge : core bus decode to DRAM and peripherals (IO_TIMER_EN adds timer)
// Rev 1.0
// ----------------------------------------------------------------------------
module io_bus_bridge
  import io_bus_bridge_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          CTRL_W    = 2,
  parameter logic [31:0] PERI_BASE = PERI_BASE_DEF,
  parameter int          SW_W      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [CTRL_W-1:0] cpu_ctrl,
  input  logic [DATA_W-1:0] cpu_wd,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rd,
  output logic [ADDR_W-3:0] dram_addr,
  output logic [DATA_W-1:0] dram_wd,
  output logic [3:0]        dram_be,
  output logic              dram_we,
  input  logic [DATA_W-1:0] dram_rd,
  input  logic [SW_W-1:0]   sw_i,
  output logic [SW_W-1:0]   led_o,
  output logic [31:0]       tube_o,
  output logic              misalign_o,
  output logic              timer_irq_o
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(PERI_BASE);

  logic [3:0]        be;
  logic [31:0]       lane_wd;
  logic              misalign;
  logic              peri_hit;
  logic              wr_ok;
  logic [ADDR_W-1:0] off_word;
  rd_sel_e           sel_d, sel_q;
  logic [DATA_W-1:0] peri_rd_d, peri_rd_q;
  logic [31:0]       tube_d, tube_q;
  logic [31:0]       led_wide;
  logic [SW_W-1:0]   led_d, led_q;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic              misalign_d, misalign_q;

  io_lane_gen u_lane (
    .addr_lo_i  (cpu_addr[1:0]),
    .size_i     (cpu_ctrl[1:0]),
    .wd_i       (cpu_wd[31:0]),
    .be_o       (be),
    .data_o     (lane_wd),
    .misalign_o (misalign)
  );

  assign peri_hit  = cpu_addr >= BASE_A;
  assign off_word  = (cpu_addr - BASE_A) & ~ADDR_W'(3);
  assign wr_ok     = cpu_we & ~misalign;

  assign dram_addr = cpu_addr[ADDR_W-1:2];
  assign dram_wd   = lane_wd;
  assign dram_be   = be;
  assign dram_we   = wr_ok & ~peri_hit & rst_n;

  always_comb begin
    sel_d = SEL_NONE;
    if (!peri_hit) begin
      sel_d = SEL_DRAM;
    end else begin
      case (off_word)
        ADDR_W'(OFF_TUBE): sel_d = SEL_TUBE;
        ADDR_W'(OFF_LED):  sel_d = SEL_LED;
        ADDR_W'(OFF_SW):   sel_d = SEL_SW;
`ifdef IO_TIMER_EN
        ADDR_W'(OFF_CNT):  sel_d = SEL_CNT;
        ADDR_W'(OFF_CMP):  sel_d = SEL_CMP;
        ADDR_W'(OFF_STAT): sel_d = SEL_STAT;
`endif
        default:           sel_d = SEL_NONE;
      endcase
    end
  end

`ifdef IO_TIMER_EN
  logic [31:0] cnt_d, cnt_q, cmp_d, cmp_q;
  logic        match_d, match_q;

  // A fresh match is applied last so it beats a same-cycle clear.
  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    cmp_d   = cmp_q;
    match_d = match_q;
    if (wr_ok && sel_d == SEL_CNT) cnt_d = lane_merge(cnt_q, lane_wd, be);
    if (wr_ok && sel_d == SEL_CMP) cmp_d = lane_merge(cmp_q, lane_wd, be);
    if (wr_ok && sel_d == SEL_STAT && be[0] && lane_wd[0]) match_d = 1'b0;
    if (cnt_q == cmp_q && cmp_q != 32'd0) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  assign timer_irq_o = match_q;
`else
  assign timer_irq_o = 1'b0;
`endif

  always_comb begin
    peri_rd_d = '0;
    case (sel_d)
      SEL_TUBE: peri_rd_d = DATA_W'(tube_q);
      SEL_LED:  peri_rd_d = DATA_W'(led_q);
      SEL_SW:   peri_rd_d = DATA_W'(sw_sync_q);
`ifdef IO_TIMER_EN
      SEL_CNT:  peri_rd_d = DATA_W'(cnt_q);
      SEL_CMP:  peri_rd_d = DATA_W'(cmp_q);
      SEL_STAT: peri_rd_d = DATA_W'(match_q);
`endif
      default:  peri_rd_d = '0;
    endcase
  end

  always_comb begin
    tube_d     = tube_q;
    led_wide   = lane_merge(32'(led_q), lane_wd, be);
    led_d      = led_q;
    misalign_d = misalign_q | (cpu_we & misalign);
    if (wr_ok && sel_d == SEL_TUBE) tube_d = lane_merge(tube_q, lane_wd, be);
    if (wr_ok && sel_d == SEL_LED)  led_d  = led_wide[SW_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q      <= SEL_NONE;
      peri_rd_q  <= '0;
      tube_q     <= '0;
      led_q      <= '0;
      misalign_q <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      sel_q      <= sel_d;
      peri_rd_q  <= peri_rd_d;
      tube_q     <= tube_d;
      led_q      <= led_d;
      misalign_q <= misalign_d;
      sw_meta_q  <= sw_i;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // DRAM data arrives one cycle after its address, aligned with sel_q.
  always_comb begin
    case (sel_q)
      SEL_DRAM: cpu_rd = dram_rd;
      SEL_NONE: cpu_rd = '0;
      default:  cpu_rd = peri_rd_q;
    endcase
  end

  assign led_o      = led_q;
  assign tube_o     = tube_q;
  assign misalign_o = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_io_bus_bridge : random and directed accesses against a byte-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_io_bus_bridge;

  localparam logic [31:0] PB = 32'hFFFF_F000;
  localparam logic [31:0] OFFS [7] = '{32'h000, 32'h060, 32'h070, 32'h020,
                                       32'h024, 32'h028, 32'h040};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd, dram_wd, dram_rd, tube_o;
  logic [1:0]  cpu_ctrl;
  logic        cpu_we, dram_we, misalign_o, timer_irq_o;
  logic [29:0] dram_addr;
  logic [3:0]  dram_be;
  logic [23:0] sw_i, led_o;

  always #5 clk = ~clk;

  io_bus_bridge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_addr    (cpu_addr),
    .cpu_ctrl    (cpu_ctrl),
    .cpu_wd      (cpu_wd),
    .cpu_we      (cpu_we),
    .cpu_rd      (cpu_rd),
    .dram_addr   (dram_addr),
    .dram_wd     (dram_wd),
    .dram_be     (dram_be),
    .dram_we     (dram_we),
    .dram_rd     (dram_rd),
    .sw_i        (sw_i),
    .led_o       (led_o),
    .tube_o      (tube_o),
    .misalign_o  (misalign_o),
    .timer_irq_o (timer_irq_o)
  );

  // Synchronous-read DRAM attached to the bridge.
  logic [31:0] dram_mem [256];
  always @(posedge clk) begin
    dram_rd <= dram_mem[dram_addr[7:0]];
    if (dram_we) begin
      for (int i = 0; i < 4; i++)
        if (dram_be[i]) dram_mem[dram_addr[7:0]][8*i +: 8] <= dram_wd[8*i +: 8];
    end
  end

  logic [31:0] ref_mem [256];
  logic [31:0] m_tube, m_cnt, m_cmp, exp_rd, obs_wd;
  logic [23:0] m_led, m_sw1, m_sw2;
  logic        m_mis, m_match, exp_valid, obs_we;
  logic [3:0]  obs_be;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Access of n bytes occupies the n-aligned lanes holding addr; misaligned if addr % n != 0.
  function automatic void lanes(input logic [1:0] lo, input logic [1:0] c, input logic [31:0] wd,
                                output logic [3:0] be, output logic [31:0] lw, output logic mis);
    int n, l, base;
    n    = (c == 2'd0) ? 1 : (c == 2'd1) ? 2 : 4;
    l    = int'(lo);
    mis  = (l % n) != 0;
    base = l - (l % n);
    for (int i = 0; i < 4; i++) begin
      lw[8*i +: 8] = wd[8*(i % n) +: 8];
      be[i] = !mis && (i >= base) && (i < base + n);
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    if (a < PB) return ref_mem[a[9:2]];
    off = (a - PB) & 32'hFFFF_FFFC;
    case (off)
      32'h000: return m_tube;
      32'h060: return {8'h0, m_led};
      32'h070: return {8'h0, m_sw2};
`ifdef IO_TIMER_EN
      32'h020: return m_cnt;
      32'h024: return m_cmp;
      32'h028: return {31'h0, m_match};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_tube = '0; m_led = '0; m_cnt = '0; m_cmp = '0; m_match = 1'b0; m_mis = 1'b0;
    m_sw1 = '0; m_sw2 = '0; exp_rd = '0; exp_valid = 1'b1;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic [1:0] c, input logic [31:0] d,
                            input logic w);
    logic [3:0]  be;
    logic [31:0] lw, off, old_cnt, led32;
    logic        mis, hit_match;
    lanes(a[1:0], c, d, be, lw, mis);
    off       = (a - PB) & 32'hFFFF_FFFC;
    hit_match = (m_cnt == m_cmp) && (m_cmp != 0);
    old_cnt   = m_cnt;
    m_cnt     = m_cnt + 1;
    if (w && mis) m_mis = 1'b1;
    if (w && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          if (a < PB) ref_mem[a[9:2]][8*i +: 8] = lw[8*i +: 8];
          else if (off == 32'h000) m_tube[8*i +: 8] = lw[8*i +: 8];
        end
      end
      if (a >= PB && off == 32'h060) begin
        led32 = {8'h0, m_led};
        for (int i = 0; i < 4; i++) if (be[i]) led32[8*i +: 8] = lw[8*i +: 8];
        m_led = led32[23:0];
      end
`ifdef IO_TIMER_EN
      if (a >= PB && off == 32'h020) begin
        m_cnt = old_cnt;
        for (int i = 0; i < 4; i++) if (be[i]) m_cnt[8*i +: 8] = lw[8*i +: 8];
      end
      if (a >= PB && off == 32'h024)
        for (int i = 0; i < 4; i++) if (be[i]) m_cmp[8*i +: 8] = lw[8*i +: 8];
      if (a >= PB && off == 32'h028 && be[0] && lw[0]) m_match = 1'b0;
`endif
    end
    if (hit_match) m_match = 1'b1;
    m_sw2 = m_sw1;
    m_sw1 = sw_i;
  endtask

  // One bus cycle: drive, check combinational outputs and previous read, clock, check state.
  task automatic step(input logic [31:0] a, input logic [1:0] c, input logic [31:0] d,
                      input logic w);
    logic [3:0]  be;
    logic [31:0] lw;
    logic        mis;
    cpu_addr = a; cpu_ctrl = c; cpu_wd = d; cpu_we = w;
    lanes(a[1:0], c, d, be, lw, mis);
    @(negedge clk);
    if (exp_valid) check_eq("cpu_rd", cpu_rd, exp_rd);
    obs_be = dram_be; obs_wd = dram_wd; obs_we = dram_we;
    check_eq("dram_addr", dram_addr, a[31:2]);
    check_eq("dram_we", dram_we, w && !mis && (a < PB));
    if (w && !mis && (a < PB)) begin
      check_eq("dram_be", dram_be, be);
      check_eq("dram_wd", dram_wd, lw);
    end
    exp_rd    = model_read(a);
    exp_valid = !w;
    @(posedge clk);
    model_edge(a, c, d, w);
    #1;
    check_eq("tube_o", tube_o, m_tube);
    check_eq("led_o", led_o, m_led);
    check_eq("misalign_o", misalign_o, m_mis);
    check_eq("timer_irq_o", timer_irq_o, m_match);
  endtask

  task automatic reset_cycles(input int n, input logic [31:0] a, input logic [31:0] d,
                              input logic w);
    cpu_addr = a; cpu_ctrl = 2'b10; cpu_wd = d; cpu_we = w; rst_n = 1'b0;
    repeat (n) @(posedge clk);
    model_reset();
    #1;
    rst_n  = 1'b1;
    cpu_we = 1'b0;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) begin
      dram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    dram_rd = '0; sw_i = '0; rst_n = 1'b0;
    cpu_addr = '0; cpu_ctrl = '0; cpu_wd = '0; cpu_we = 1'b0;
    model_reset();
    reset_cycles(3, 32'h0, 32'h0, 1'b0);
    check_eq("rst_cpu_rd", cpu_rd, 0);
    check_eq("rst_led", led_o, 0);
    check_eq("rst_tube", tube_o, 0);
    check_eq("rst_misalign", misalign_o, 0);
    check_eq("rst_irq", timer_irq_o, 0);

    step(32'h100, 2'b10, 32'h1234_5678, 1'b1);
    check_eq("wr_word_be", obs_be, 4'b1111);
    step(32'h100, 2'b10, 32'h0, 1'b0);
    check_eq("rd_word", cpu_rd, 32'h1234_5678);
    step(32'h103, 2'b00, 32'h0000_00AB, 1'b1);
    check_eq("byte_be", obs_be, 4'b1000);
    check_eq("byte_wd", obs_wd, 32'hABAB_ABAB);
    step(32'h102, 2'b01, 32'h0000_BEEF, 1'b1);
    check_eq("half_be", obs_be, 4'b1100);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      if ($urandom_range(1, 0) == 1) a = $urandom_range(32'h3FF, 0);
      else a = PB + OFFS[$urandom_range(6, 0)] + 32'($urandom_range(3, 0));
      if ($urandom_range(15, 0) == 0) sw_i = 24'($urandom);
      step(a, 2'($urandom_range(3, 0)), $urandom, 1'($urandom_range(1, 0)));
    end

    reset_cycles(2, 32'h0, 32'h0, 1'b0);
    step(32'h101, 2'b01, 32'h0000_1234, 1'b1);
    check_eq("mis_flag", misalign_o, 1);
    check_eq("mis_dram_we", obs_we, 0);
    step(PB + 32'h062, 2'b10, 32'hFFFF_FFFF, 1'b1);
    check_eq("mis_led", led_o, 0);

    sw_i = 24'h00A55A;
    step(32'h0, 2'b10, 32'h0, 1'b0);
    step(32'h0, 2'b10, 32'h0, 1'b0);
    step(PB + 32'h070, 2'b10, 32'h0, 1'b0);
    check_eq("sw_read", cpu_rd, 32'h0000_A55A);
    step(PB + 32'h061, 2'b00, 32'h0000_00FF, 1'b1);
    check_eq("led_byte", led_o, 24'h00FF00);

`ifdef IO_TIMER_EN
    step(PB + 32'h020, 2'b10, 32'd100, 1'b1);
    step(PB + 32'h024, 2'b10, 32'd10, 1'b1);
    step(PB + 32'h028, 2'b10, 32'd1, 1'b1);
    step(PB + 32'h020, 2'b10, 32'd0, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step(32'h0, 2'b10, 32'h0, 1'b0);
      if (timer_irq_o) lat = k;
    end
    check_eq("irq_latency", lat, 11);
    step(PB + 32'h028, 2'b10, 32'd1, 1'b1);
    check_eq("irq_w1c", timer_irq_o, 0);
    step(PB + 32'h020, 2'b10, 32'hFFFF_FFFF, 1'b1);
    step(32'h0, 2'b10, 32'h0, 1'b0);
    step(PB + 32'h020, 2'b10, 32'h0, 1'b0);
    check_eq("cnt_wrap", cpu_rd, 0);
`else
    lat = 0;
    step(PB + 32'h024, 2'b10, 32'd5, 1'b1);
    step(PB + 32'h024, 2'b10, 32'h0, 1'b0);
    check_eq("timer_off_rd", cpu_rd, lat);
`endif

    reset_cycles(1, PB, 32'hDEAD_BEEF, 1'b1);
    check_eq("rst_wr_tube", tube_o, 0);
    check_eq("rst_wr_rd", cpu_rd, 0);
    step(PB, 2'b10, 32'h0, 1'b0);
    step(32'h0, 2'b10, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_bus_bridge.md
Name: io_bus_bridge

Overview:
- Sits directly downstream of the mini RISC-V core's memory/IO bus; consumes the address, ctrl, write-data and write-enable the core drives.
- Decodes each access to DRAM or to one of the memory-mapped peripherals (LED, switches, 7-seg tube, timer).
- Generates per-byte write enables and returns read data to the core with a fixed latency of one cycle.

Parameters:
- ADDR_W, 32, bus address width (matches IO_BUS_WIDTH_ADDR)
- DATA_W, 32, bus data width (matches IO_BUS_WIDTH_DATA)
- CTRL_W, 2, access size code width (matches IO_BUS_WIDTH_CTRL)
- PERI_BASE, 32'hFFFF_F000, first peripheral address; addresses >= PERI_BASE are peripheral, all others are DRAM
- SW_W, 24, switch/LED width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- cpu_addr  in  ADDR_W  byte address from core
- cpu_ctrl  in  CTRL_W  size code: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- cpu_wd  in  DATA_W  write data, right-aligned
- cpu_we  in  1  write strobe
- cpu_rd  out  DATA_W  full aligned word read; the core performs sign/zero extension
- dram_addr  out  ADDR_W-2  word address to DRAM
- dram_wd  out  DATA_W  lane-replicated write data
- dram_be  out  4  byte enables, qualified by dram_we
- dram_we  out  1  DRAM write strobe
- dram_rd  in  DATA_W  DRAM read word, synchronous (valid one cycle after dram_addr)
- sw_i  in  SW_W  asynchronous switch inputs
- led_o  out  SW_W  LED register
- tube_o  out  32  7-seg display value register
- misalign_o  out  1  sticky misaligned-write flag
- timer_irq_o  out  1  timer match flag (IO_TIMER_EN only; otherwise tied 0)

Behaviour:
- Map: 0x000 tube (RW); 0x060 LED (RW); 0x070 switches (RO); 0x020 timer count (RW); 0x024 timer compare (RW); 0x028 timer status (bit0 = match, write-1-to-clear). Offsets are relative to PERI_BASE. Unmapped peripheral offsets read 0 and ignore writes.
- Lane generation:
  - byte: be = 1<<addr[1:0]; data = {4{wd[7:0]}}
  - half: be = addr[1] ? 1100 : 0011; data = {2{wd[15:0]}}
  - word: be = 1111; data = wd
- Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - Misaligned writes are suppressed (be = 0000, no register update) and set misalign_o.
  - misalign_o clears only on reset.
  - Misaligned reads proceed at the word address.
- DRAM outputs are combinational from the cpu_* inputs. dram_we = cpu_we & DRAM hit & aligned.
- Peripheral registers update on the clk edge under cpu_we & hit & aligned; byte enables are honoured per lane.
- Read path: the decode select (dram / tube / led / sw / timer regs / none) and the peripheral read word are registered at the edge. cpu_rd is the mux output one cycle after the address is presented, in the same cycle the registered DRAM data is valid.
- Read-after-write to the same peripheral register in consecutive cycles returns the new value.
- Switches: two-flop synchronizer; reads return the synchronized value zero-extended.
- Reset values: led_o 0, tube_o 0, misalign_o 0, timer count/compare/match 0, read select = none (cpu_rd = 0 in the cycle after reset release).
- Reset asserted mid-access: any write presented in that cycle is discarded.

Optional Feature:
- Macro IO_TIMER_EN.
- Defined:
  - 32-bit count increments each clk, wrapping 0xFFFF_FFFF -> 0.
  - A CPU write to the count register takes priority over the increment in that cycle.
  - When count == compare and compare != 0, match sets on the next edge; timer_irq_o = match.
  - If a W1C write and a new match occur in the same cycle, the match wins (flag stays 1).
- Not defined: timer offsets behave as unmapped, timer_irq_o = 0, and no timer flops are present.

Decomposition:
- Shared package/param header:
  - size codes (SIZE_B/H/W)
  - PERI_BASE
  - offset constants
  - read-select enum
- One natural sub-module: io_lane_gen. It is combinational and maps addr[1:0], size and wd to be, replicated data and the misalign bit. It is reused by the DRAM and peripheral paths.

Test Plan:
- Word write 0x1234_5678 to DRAM 0x100, then word read 0x100 -> dram_be=1111 on the write; cpu_rd=0x1234_5678 one cycle after the read address.
- Byte write 0xAB to 0x103 -> dram_be=1000, dram_wd=0xABAB_ABAB; half write 0xBEEF to 0x102 -> be=1100.
- Half write to 0x101, then word write to LED at PERI_BASE+0x062 -> both suppressed, led_o unchanged, misalign_o=1 from the first edge.
- sw_i=0x00A5_5A -> read of PERI_BASE+0x070, issued at least 2 cycles after sw_i changes, returns 0x0000_A55A; LED byte write 0xFF at +0x061 -> led_o=0x00FF00.
- IO_TIMER_EN: write compare=10, count=0 -> timer_irq_o rises 11 cycles after the count write; W1C to +0x028 clears it; writing count=0xFFFF_FFFF then waiting 1 cycle reads 0.
- Assert rst_n=0 in the same cycle as a tube write of 0xDEAD_BEEF -> tube_o stays 0, and cpu_rd=0 on the first cycle after release.
